dmem_mmio_responder: RTL and testbench



---
 rtl/dmem_mmio_pkg.sv | 19 +
 rtl/dmem_mmio_responder_if.sv | 14 +
 rtl/uart_tx_8n1.sv | 103 ++++++++++
 rtl/dmem_mmio_responder.sv | 100 ++++++++++
 tb/tb_dmem_mmio_responder.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-memory / MMIO responder.
//   MMIO_BASE_BIT : address bit that selects the peripheral page over RAM
//   OFF_*         : word offsets (addr[4:2]) within the peripheral page
//   UART_*        : UART transmitter state encoding
package dmem_mmio_pkg;

  localparam int unsigned MMIO_BASE_BIT = 31;

  localparam logic [2:0] OFF_LED    = 3'd0;
  localparam logic [2:0] OFF_TXDATA = 3'd1;
  localparam logic [2:0] OFF_STATUS = 3'd2;
  localparam logic [2:0] OFF_TIMER  = 3'd3;

  localparam logic [1:0] UART_IDLE  = 2'd0;
  localparam logic [1:0] UART_START = 2'd1;
  localparam logic [1:0] UART_DATA  = 2'd2;
  localparam logic [1:0] UART_STOP  = 2'd3;

endpackage

// File: rtl/dmem_mmio_responder_if.sv
// Core data-bus bundle.
//   mem_addr  : byte address from the core
//   mem_we    : write strobe
//   mem_wdata : store data
//   mem_rdata : load data, returned combinationally by the responder
interface dmem_mmio_responder_if;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (output mem_addr, output mem_we, output mem_wdata, input mem_rdata);
  modport slave  (input mem_addr, input mem_we, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/uart_tx_8n1.sv
// 8N1 serial transmitter: start bit, eight data bits LSB first, one stop bit.
//   clk, reset : clock and asynchronous active-high reset
//   start      : request a frame; ignored while busy
//   data       : byte captured with an accepted start
//   busy       : high from the cycle after acceptance until the stop bit ends
//   tx         : registered serial line, idles high
module uart_tx_8n1
  import dmem_mmio_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 234
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            tx_q, tx_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    case (state_q)
      UART_IDLE: begin
        if (start) begin
          state_d = UART_START;
          cnt_d   = CntLast;
          shreg_d = data;
        end
      end
      UART_START: begin
        if (cnt_q == '0) begin
          state_d = UART_DATA;
          cnt_d   = CntLast;
          idx_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      UART_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = CntLast;
          if (idx_q == 3'd7) begin
            state_d = UART_STOP;
          end else begin
            idx_d   = idx_q + 3'd1;
            shreg_d = {1'b0, shreg_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      UART_STOP: begin
        if (cnt_q == '0) begin
          state_d = UART_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = UART_IDLE;
    endcase
  end

  // Line level is computed from next state so tx changes on the same edge as the state.
  always_comb begin
    case (state_d)
      UART_START: tx_d = 1'b0;
      UART_DATA:  tx_d = shreg_d[0];
      default:    tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= UART_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shreg_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  assign busy = (state_q != UART_IDLE);
  assign tx   = tx_q;

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-bus responder for the single-cycle core: word RAM below 0x8000_0000,
// peripheral page (LED, UART TX, status, cycle timer) at and above it.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : core data bus (slave side); read data is combinational
//   led        : LED register contents
//   uart_tx    : serial output, idles high
module dmem_mmio_responder
  import dmem_mmio_pkg::*;
#(
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned CLKS_PER_BIT = 234,
  parameter int unsigned LED_W        = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_mmio_responder_if.slave bus,
  output logic [LED_W-1:0]     led,
  output logic                 uart_tx
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0]      ram_q [DEPTH];
  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      timer_q, timer_d;

  logic [AW-1:0] ram_idx;
  logic [2:0]    off;
  logic          sel_mmio, wr_ram, wr_mmio, uart_start, uart_busy;

  assign sel_mmio = bus.mem_addr[MMIO_BASE_BIT];
  assign ram_idx  = bus.mem_addr[AW+1:2];
  assign off      = bus.mem_addr[4:2];
  assign wr_ram   = bus.mem_we & ~sel_mmio;
  assign wr_mmio  = bus.mem_we & sel_mmio;

  // Byte lane bits and aliased upper RAM bits are don't-care.
  logic unused_addr;
  assign unused_addr = ^{bus.mem_addr[30:AW+2], bus.mem_addr[1:0]};

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ram) begin
      ram_q[ram_idx] <= bus.mem_wdata;
    end
  end

  always_comb begin
    led_d   = led_q;
    timer_d = timer_q + 32'd1;
    if (wr_mmio && off == OFF_LED) begin
      led_d = bus.mem_wdata[LED_W-1:0];
    end
    // A software load takes priority over the increment.
    if (wr_mmio && off == OFF_TIMER) begin
      timer_d = bus.mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q   <= '0;
      timer_q <= 32'd0;
    end else begin
      led_q   <= led_d;
      timer_q <= timer_d;
    end
  end

  // Writes while a frame is in flight are dropped.
  assign uart_start = wr_mmio && (off == OFF_TXDATA) && !uart_busy;

  uart_tx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk  (clk),
    .reset(reset),
    .start(uart_start),
    .data (bus.mem_wdata[7:0]),
    .busy (uart_busy),
    .tx   (uart_tx)
  );

  always_comb begin
    bus.mem_rdata = 32'd0;
    if (!sel_mmio) begin
      bus.mem_rdata = ram_q[ram_idx];
    end else begin
      case (off)
        OFF_LED:    bus.mem_rdata = 32'(led_q);
        OFF_STATUS: bus.mem_rdata = {31'd0, uart_busy};
        OFF_TIMER:  bus.mem_rdata = timer_q;
        default:    bus.mem_rdata = 32'd0;
      endcase
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
module tb_dmem_mmio_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned CPB   = 4;
  localparam int unsigned LED_W = 6;

  localparam logic [31:0] A_LED    = 32'h8000_0000;
  localparam logic [31:0] A_TXDATA = 32'h8000_0004;
  localparam logic [31:0] A_STATUS = 32'h8000_0008;
  localparam logic [31:0] A_TIMER  = 32'h8000_000C;

  logic clk = 1'b0;
  logic reset;
  logic [LED_W-1:0] led;
  logic uart_tx;

  always #5 clk = ~clk;

  dmem_mmio_responder_if bus ();

  dmem_mmio_responder #(
    .DEPTH       (DEPTH),
    .CLKS_PER_BIT(CPB),
    .LED_W       (LED_W)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .led    (led),
    .uart_tx(uart_tx)
  );

  // Reference model state
  logic [31:0]      ram_m [int unsigned];
  logic [LED_W-1:0] led_m;
  logic [31:0]      tim_m;
  bit               m_active;
  int               m_pos;
  logic [7:0]       m_byte;

  int tests = 0;
  int fails = 0;
  logic [31:0] rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Frame is start(0), eight data bits LSB first, stop(1); each slot CPB cycles.
  function automatic logic exp_tx();
    int slot;
    if (!m_active) return 1'b1;
    slot = m_pos / CPB;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return m_byte[slot-1];
  endfunction

  function automatic bit read_known(input logic [31:0] a);
    if (a >= 32'h8000_0000) return 1'b1;
    return ram_m.exists((a / 4) % DEPTH);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int unsigned off;
    off = (a / 4) % 8;
    if (a < 32'h8000_0000) return ram_m[(a / 4) % DEPTH];
    case (off)
      0:       return 32'(led_m);
      2:       return {31'd0, m_active};
      3:       return tim_m;
      default: return 32'd0;
    endcase
  endfunction

  // One bus cycle: drive just after the edge, sample mid-cycle, advance model at the edge.
  task automatic cyc(input logic [31:0] a, input bit we, input logic [31:0] wd);
    bit mmio;
    int unsigned off;
    bit accept;
    bus.mem_addr  = a;
    bus.mem_we    = we;
    bus.mem_wdata = wd;
    #4;
    rd = bus.mem_rdata;
    check("uart_tx", 32'(uart_tx), 32'(exp_tx()));
    check("led", 32'(led), 32'(led_m));
    if (read_known(a)) check("rdata", rd, model_read(a));
    mmio   = (a >= 32'h8000_0000);
    off    = (a / 4) % 8;
    accept = we && mmio && off == 1 && !m_active;
    if (m_active) begin
      m_pos++;
      if (m_pos == 10 * CPB) m_active = 1'b0;
    end
    if (accept) begin
      m_active = 1'b1;
      m_pos    = 0;
      m_byte   = wd[7:0];
    end
    if (we && mmio && off == 3) tim_m = wd;
    else tim_m = tim_m + 32'd1;
    if (we && mmio && off == 0) led_m = wd[LED_W-1:0];
    if (we && !mmio) ram_m[(a / 4) % DEPTH] = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    led_m    = '0;
    tim_m    = 32'd0;
    m_active = 1'b0;
    m_pos    = 0;
  endtask

  initial begin
    int busy_cnt;
    int guard;
    int unsigned r;
    logic [31:0] a;

    reset         = 1'b1;
    bus.mem_addr  = 32'd0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Timer counts 0,1,2,3 from the deassert cycle; status idle
    repeat (4) cyc(A_TIMER, 1'b0, 32'd0);
    cyc(A_STATUS, 1'b0, 32'd0);
    check("status_after_reset", rd, 32'd0);

    // RAM round trip, aliasing, and ignored byte-lane bits
    cyc(32'h0000_0010, 1'b1, 32'hDEAD_BEEF);
    cyc(32'h0000_0010, 1'b0, 32'd0);
    check("ram_rt", rd, 32'hDEAD_BEEF);
    cyc(32'h0000_0410, 1'b0, 32'd0);
    check("ram_alias", rd, 32'hDEAD_BEEF);
    cyc(32'h0000_0013, 1'b0, 32'd0);
    check("ram_bytelane", rd, 32'hDEAD_BEEF);

    // LED register
    cyc(A_LED, 1'b1, 32'hFFFF_FFAA);
    check("led_val", 32'(led), 32'h2A);
    cyc(A_LED, 1'b0, 32'd0);
    check("led_read", rd, 32'h0000_002A);
    cyc(32'h0000_0000, 1'b1, 32'h1234_5678);
    cyc(A_LED, 1'b0, 32'd0);
    check("led_after_ram_wr", 32'(led), 32'h2A);

    // UART frame 0x55, busy for exactly 10*CPB cycles
    cyc(A_TXDATA, 1'b1, 32'h0000_0055);
    busy_cnt = 0;
    repeat (10 * CPB + 5) begin
      cyc(A_STATUS, 1'b0, 32'd0);
      busy_cnt += int'(rd[0]);
    end
    check("busy_cycles", 32'(busy_cnt), 32'(10 * CPB));
    cyc(A_TXDATA, 1'b0, 32'd0);
    check("txdata_read", rd, 32'd0);

    // Write while busy is dropped; write on first idle cycle starts a new frame
    cyc(A_TXDATA, 1'b1, 32'h0000_0055);
    repeat (10) cyc(A_STATUS, 1'b0, 32'd0);
    cyc(A_TXDATA, 1'b1, 32'h0000_00A5);
    guard = 0;
    while (m_active && guard < 100) begin
      cyc(A_STATUS, 1'b0, 32'd0);
      guard++;
    end
    cyc(A_TXDATA, 1'b1, 32'h0000_000F);
    cyc(A_STATUS, 1'b0, 32'd0);
    check("new_frame_busy", rd, 32'd1);
    check("new_frame_start", 32'(uart_tx), 32'd0);
    guard = 0;
    while (m_active && guard < 100) begin
      cyc(A_STATUS, 1'b0, 32'd0);
      guard++;
    end

    // Timer load and wrap
    cyc(A_TIMER, 1'b1, 32'hFFFF_FFFE);
    cyc(A_TIMER, 1'b0, 32'd0);
    check("timer_load", rd, 32'hFFFF_FFFE);
    cyc(A_TIMER, 1'b0, 32'd0);
    check("timer_max", rd, 32'hFFFF_FFFF);
    cyc(A_TIMER, 1'b0, 32'd0);
    check("timer_wrap", rd, 32'h0000_0000);
    cyc(32'h8000_0014, 1'b0, 32'd0);
    check("unmapped", rd, 32'd0);

    // Reset in the middle of a frame
    cyc(A_LED, 1'b1, 32'h0000_0015);
    cyc(A_TXDATA, 1'b1, 32'h0000_0000);
    repeat (6) cyc(A_STATUS, 1'b0, 32'd0);
    bus.mem_addr = A_TIMER;
    bus.mem_we   = 1'b0;
    reset        = 1'b1;
    #1;
    check("rst_tx", 32'(uart_tx), 32'd1);
    check("rst_led", 32'(led), 32'd0);
    check("rst_timer", bus.mem_rdata, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    repeat (4) cyc(A_TIMER, 1'b0, 32'd0);
    cyc(A_STATUS, 1'b0, 32'd0);
    check("rst_status", rd, 32'd0);
    repeat (2 * 10 * CPB) cyc(A_STATUS, 1'b0, 32'd0);

    // Randomized traffic against the model
    repeat (600) begin
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3))
            | (32'($urandom_range(0, 3)) << 10);
        cyc(a, (r <= 3), $urandom);
      end else begin
        a = A_LED | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
        cyc(a, (r == 6), $urandom);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
